// File: rtl/cache_pkg.sv
// Shared types and default sizing for the cache refill arbiter slice.
package cache_pkg;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_LINE_WORDS = 4;

    localparam int LINE_W = DEF_LINE_WORDS * DEF_DATA_W;
    localparam int OFF_W  = $clog2(DEF_LINE_WORDS);

    // Clears the word-offset and byte-offset bits of a byte address.
    localparam logic [DEF_ADDR_W-1:0] LINE_MASK = ~((DEF_ADDR_W)'((DEF_LINE_WORDS * 4) - 1));

    typedef enum logic [2:0] {
        IDLE,
        I_RD,
        D_WR,
        D_RD,
        I_DONE,
        D_DONE
    } state_t;

endpackage

// File: rtl/cache_refill_arbiter_if.sv
// Word-wide memory bus between the refill arbiter (master) and main memory (slave).
interface cache_refill_arbiter_if
    import cache_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              MemReq;
    logic              MemWe;
    logic [ADDR_W-1:0] MemAddr;
    logic [DATA_W-1:0] MemWData;
    logic [DATA_W-1:0] MemRData;
    logic              MemAck;

    modport master (
        output MemReq, MemWe, MemAddr, MemWData,
        input  MemRData, MemAck
    );

    modport slave (
        input  MemReq, MemWe, MemAddr, MemWData,
        output MemRData, MemAck
    );

endinterface

// File: rtl/cache_refill_arbiter_mem_burst_ctr.sv
// Word index within a line burst; advances on each accepted word and wraps after the last.
module mem_burst_ctr #(
    parameter int LINE_WORDS = 4,
    localparam int CW = $clog2(LINE_WORDS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          adv,
    output logic [CW-1:0] cnt,
    output logic          last
);

    assign last = (cnt == CW'(LINE_WORDS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= '0;
        end else if (adv) begin
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cache_refill_arbiter.sv
// Arbitrates ICache/DCache line refills onto one memory word port,
// running a DCache dirty-victim writeback burst ahead of its refill.
module cache_refill_arbiter
    import cache_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic                         clk,
    input  logic                         CpuRstN,
    input  logic                         IReq,
    input  logic [ADDR_W-1:0]            IAddr,
    output logic [LINE_WORDS*DATA_W-1:0] ILine,
    output logic                         IDone,
    input  logic                         DReq,
    input  logic [ADDR_W-1:0]            DAddr,
    input  logic                         DWbEn,
    input  logic [ADDR_W-1:0]            DWbAddr,
    input  logic [LINE_WORDS*DATA_W-1:0] DWbLine,
    output logic [LINE_WORDS*DATA_W-1:0] DLine,
    output logic                         DDone,
    cache_refill_arbiter_if.master       mem,
    output logic                         ICacheMiss,
    output logic                         DCacheMiss
);

    localparam int OW   = $clog2(LINE_WORDS);
    localparam int LA_W = ADDR_W - OW - 2;
    localparam int LW   = LINE_WORDS * DATA_W;

    state_t            state, next_state;
    logic              ptr_d, ptr_d_next;
    logic              grant_i, grant_d;
    logic              in_burst, accept;
    logic [OW-1:0]     cnt;
    logic              last;
    logic [LA_W-1:0]   i_line_addr, d_line_addr, wb_line_addr, cur_line_addr;
    logic [LW-1:0]     wb_line;

    // Offset bits of the incoming addresses are irrelevant to a line burst.
    logic unused_offset_bits;
    assign unused_offset_bits = ^{IAddr[OW+1:0], DAddr[OW+1:0], DWbAddr[OW+1:0]};

    assign in_burst = (state == I_RD) || (state == D_WR) || (state == D_RD);
    assign accept   = in_burst && mem.MemAck;

    mem_burst_ctr #(.LINE_WORDS(LINE_WORDS)) u_burst_ctr (
        .clk   (clk),
        .rst_n (CpuRstN),
        .start (grant_i | grant_d),
        .adv   (accept),
        .cnt   (cnt),
        .last  (last)
    );

    // Grant decision and burst sequencing; ptr_d set means D wins a tie.
    always_comb begin
        next_state = state;
        ptr_d_next = ptr_d;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        case (state)
            IDLE: begin
                if (IReq && (!DReq || !ptr_d)) begin
                    grant_i    = 1'b1;
                    next_state = I_RD;
                    ptr_d_next = 1'b1;
                end else if (DReq) begin
                    grant_d    = 1'b1;
                    next_state = DWbEn ? D_WR : D_RD;
                    ptr_d_next = 1'b0;
                end
            end
            I_RD:    if (accept && last) next_state = I_DONE;
            D_WR:    if (accept && last) next_state = D_RD;
            D_RD:    if (accept && last) next_state = D_DONE;
            I_DONE:  next_state = IDLE;
            D_DONE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        cur_line_addr = '0;
        case (state)
            I_RD:    cur_line_addr = i_line_addr;
            D_WR:    cur_line_addr = wb_line_addr;
            D_RD:    cur_line_addr = d_line_addr;
            default: cur_line_addr = '0;
        endcase
    end

    assign mem.MemReq   = in_burst;
    assign mem.MemWe    = (state == D_WR);
    assign mem.MemAddr  = in_burst ? {cur_line_addr, cnt, 2'b00} : '0;
    assign mem.MemWData = (state == D_WR) ? wb_line[cnt*DATA_W +: DATA_W] : '0;

    assign IDone      = (state == I_DONE);
    assign DDone      = (state == D_DONE);
    assign ICacheMiss = IReq & ~IDone;
    assign DCacheMiss = DReq & ~DDone;

    // Request context is captured at grant so requesters may change inputs mid-burst.
    always_ff @(posedge clk or negedge CpuRstN) begin
        if (!CpuRstN) begin
            state        <= IDLE;
            ptr_d        <= 1'b1;
            i_line_addr  <= '0;
            d_line_addr  <= '0;
            wb_line_addr <= '0;
            wb_line      <= '0;
            ILine        <= '0;
            DLine        <= '0;
        end else begin
            state <= next_state;
            ptr_d <= ptr_d_next;
            if (grant_i) begin
                i_line_addr <= IAddr[ADDR_W-1:OW+2];
            end
            if (grant_d) begin
                d_line_addr  <= DAddr[ADDR_W-1:OW+2];
                wb_line_addr <= DWbAddr[ADDR_W-1:OW+2];
                wb_line      <= DWbLine;
            end
            if ((state == I_RD) && accept) begin
                ILine[cnt*DATA_W +: DATA_W] <= mem.MemRData;
            end
            if ((state == D_RD) && accept) begin
                DLine[cnt*DATA_W +: DATA_W] <= mem.MemRData;
            end
        end
    end

endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Directed table-driven bench for cache_refill_arbiter plus multi-cycle corner sequences.
module tb_cache_refill_arbiter;
    import cache_pkg::*;

    localparam int AW = DEF_ADDR_W;
    localparam int DW = DEF_DATA_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_req, d_req, d_wb_en;
    logic [AW-1:0]     i_addr, d_addr, d_wb_addr;
    logic [LINE_W-1:0] d_wb_line, i_line, d_line;
    logic              i_done, d_done, i_miss, d_miss;
    logic [DW-1:0]     rd_base;
    int                tests = 0;
    int                fails = 0;

    typedef struct {
        logic        ireq, dreq, ack;
        logic [31:0] base;
        logic        exp_req, exp_we;
        logic [31:0] exp_addr, exp_wdata;
        logic        exp_idone, exp_ddone, exp_imiss, exp_dmiss;
    } vec_t;

    vec_t vecs[$];

    cache_refill_arbiter_if bus ();

    cache_refill_arbiter dut (
        .clk        (clk),
        .CpuRstN    (rst_n),
        .IReq       (i_req),
        .IAddr      (i_addr),
        .ILine      (i_line),
        .IDone      (i_done),
        .DReq       (d_req),
        .DAddr      (d_addr),
        .DWbEn      (d_wb_en),
        .DWbAddr    (d_wb_addr),
        .DWbLine    (d_wb_line),
        .DLine      (d_line),
        .DDone      (d_done),
        .mem        (bus.master),
        .ICacheMiss (i_miss),
        .DCacheMiss (d_miss)
    );

    always #5 clk = ~clk;

    // Memory returns base + word index so every line slot has a distinct value.
    assign bus.MemRData = rd_base + DW'(bus.MemAddr[OFF_W+1:2]);

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ireq, dreq, ack, input logic [31:0] base,
                                input logic req, we, input logic [31:0] addr, wdata,
                                input logic idone, ddone, imiss, dmiss);
        vec_t v;
        v.ireq = ireq; v.dreq = dreq; v.ack = ack; v.base = base;
        v.exp_req = req; v.exp_we = we; v.exp_addr = addr; v.exp_wdata = wdata;
        v.exp_idone = idone; v.exp_ddone = ddone; v.exp_imiss = imiss; v.exp_dmiss = dmiss;
        return v;
    endfunction

    task automatic apply_stimulus(input vec_t v);
        @(posedge clk);
        #1;
        i_req       = v.ireq;
        d_req       = v.dreq;
        bus.MemAck  = v.ack;
        rd_base     = v.base;
    endtask

    task automatic check_output(input vec_t v, input int r);
        #4;
        check($sformatf("row%0d MemReq", r),   128'(bus.MemReq),   128'(v.exp_req));
        check($sformatf("row%0d MemWe", r),    128'(bus.MemWe),    128'(v.exp_we));
        check($sformatf("row%0d MemAddr", r),  128'(bus.MemAddr),  128'(v.exp_addr));
        check($sformatf("row%0d MemWData", r), 128'(bus.MemWData), 128'(v.exp_wdata));
        check($sformatf("row%0d IDone", r),    128'(i_done),       128'(v.exp_idone));
        check($sformatf("row%0d DDone", r),    128'(d_done),       128'(v.exp_ddone));
        check($sformatf("row%0d ICacheMiss", r), 128'(i_miss),     128'(v.exp_imiss));
        check($sformatf("row%0d DCacheMiss", r), 128'(d_miss),     128'(v.exp_dmiss));
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        next_cycle();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] order [4];
        int         done_cnt;
        int         both;
        int         done_cyc;
        logic       last_i, last_d;

        rst_n      = 1'b0;
        i_req      = 1'b0;
        d_req      = 1'b0;
        d_wb_en    = 1'b0;
        i_addr     = '0;
        d_addr     = '0;
        d_wb_addr  = '0;
        d_wb_line  = '0;
        bus.MemAck = 1'b0;
        rd_base    = '0;

        #3;
        check("reset MemReq",   128'(bus.MemReq),   128'(0));
        check("reset MemWe",    128'(bus.MemWe),    128'(0));
        check("reset MemAddr",  128'(bus.MemAddr),  128'(0));
        check("reset MemWData", 128'(bus.MemWData), 128'(0));
        check("reset IDone",    128'(i_done),       128'(0));
        check("reset DDone",    128'(d_done),       128'(0));
        check("reset ILine",    128'(i_line),       128'(0));
        check("reset DLine",    128'(d_line),       128'(0));
        next_cycle();
        rst_n = 1'b1;

        // I refill at 0x1234, then a D writeback (0x2000) + refill (0x3000), MemAck tied high.
        i_addr    = 32'h0000_1234;
        d_wb_en   = 1'b1;
        d_wb_addr = 32'h0000_2000;
        d_wb_line = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
        d_addr    = 32'h0000_3000;
        vecs.push_back(mk(1, 0, 1, 32'hA0, 0, 0, 32'h0,    32'h0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 1, 32'hA0, 1, 0, 32'h1230, 32'h0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 1, 32'hA0, 1, 0, 32'h1234, 32'h0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 1, 32'hA0, 1, 0, 32'h1238, 32'h0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 1, 32'hA0, 1, 0, 32'h123C, 32'h0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 1, 32'hA0, 0, 0, 32'h0,    32'h0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 32'hA0, 0, 0, 32'h0,    32'h0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 32'hC0, 0, 0, 32'h0,    32'h0,  0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 32'hC0, 1, 1, 32'h2000, 32'hD0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 32'hC0, 1, 1, 32'h2004, 32'hD1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 32'hC0, 1, 1, 32'h2008, 32'hD2, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 32'hC0, 1, 1, 32'h200C, 32'hD3, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 32'hC0, 1, 0, 32'h3000, 32'h0,  0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 32'hC0, 1, 0, 32'h3004, 32'h0,  0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 32'hC0, 1, 0, 32'h3008, 32'h0,  0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 32'hC0, 1, 0, 32'h300C, 32'h0,  0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 32'hC0, 0, 0, 32'h0,    32'h0,  0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 32'hC0, 0, 0, 32'h0,    32'h0,  0, 0, 0, 0));

        foreach (vecs[r]) begin
            apply_stimulus(vecs[r]);
            check_output(vecs[r], r);
        end
        check("ILine after I refill", 128'(i_line), {32'hA3, 32'hA2, 32'hA1, 32'hA0});
        check("DLine after D refill", 128'(d_line), {32'hC3, 32'hC2, 32'hC1, 32'hC0});

        // Both sides keep re-requesting, dropping Req only in the cycle after their Done.
        d_wb_en = 1'b0;
        i_addr  = 32'h0000_4000;
        d_addr  = 32'h0000_5000;
        rd_base = 32'h11;
        pulse_reset();
        done_cnt = 0;
        both     = 0;
        last_i   = 1'b0;
        last_d   = 1'b0;
        for (int c = 0; c < 200 && done_cnt < 4; c++) begin
            next_cycle();
            i_req      = !last_i;
            d_req      = !last_d;
            bus.MemAck = 1'b1;
            #4;
            last_i = i_done;
            last_d = d_done;
            if (i_done && d_done) both++;
            if (i_done) begin
                order[done_cnt] = "I";
                done_cnt++;
            end else if (d_done) begin
                order[done_cnt] = "D";
                done_cnt++;
            end
        end
        next_cycle();
        i_req = 1'b0;
        d_req = 1'b0;
        check("rr completions", 128'(done_cnt), 128'(4));
        check("rr both done", 128'(both), 128'(0));
        check("rr grant 0", 128'(order[0]), 128'("D"));
        check("rr grant 1", 128'(order[1]), 128'("I"));
        check("rr grant 2", 128'(order[2]), 128'("D"));
        check("rr grant 3", 128'(order[3]), 128'("I"));

        // I refill with two wait cycles before every accepted word.
        i_addr  = 32'h0000_5678;
        rd_base = 32'h50;
        next_cycle();
        i_req      = 1'b1;
        bus.MemAck = 1'b0;
        #4;
        for (int k = 1; k <= 12; k++) begin
            next_cycle();
            bus.MemAck = ((k % 3) == 0);
            #4;
            check($sformatf("wait c%0d MemReq", k), 128'(bus.MemReq), 128'(1));
            check($sformatf("wait c%0d MemAddr", k), 128'(bus.MemAddr),
                  128'(32'h5670 + 32'(4 * ((k - 1) / 3))));
            check($sformatf("wait c%0d IDone", k), 128'(i_done), 128'(0));
        end
        next_cycle();
        bus.MemAck = 1'b0;
        #4;
        check("wait IDone c13", 128'(i_done), 128'(1));
        next_cycle();
        i_req = 1'b0;
        check("wait ILine", 128'(i_line), {32'h53, 32'h52, 32'h51, 32'h50});

        // Reset asserted during the second word of a D_RD burst.
        d_addr  = 32'h0000_6000;
        rd_base = 32'h60;
        next_cycle();
        d_req      = 1'b1;
        bus.MemAck = 1'b1;
        next_cycle();
        next_cycle();
        #1;
        rst_n = 1'b0;
        d_req = 1'b0;
        #1;
        check("midrst MemReq", 128'(bus.MemReq), 128'(0));
        check("midrst MemAddr", 128'(bus.MemAddr), 128'(0));
        check("midrst DDone", 128'(d_done), 128'(0));
        check("midrst DLine", 128'(d_line), 128'(0));
        next_cycle();
        rst_n   = 1'b1;
        d_addr  = 32'h0000_7000;
        rd_base = 32'h70;
        next_cycle();
        d_req = 1'b1;
        #4;
        done_cyc = -1;
        for (int c = 1; c <= 20 && done_cyc < 0; c++) begin
            next_cycle();
            #4;
            if (d_done) done_cyc = c;
        end
        next_cycle();
        d_req = 1'b0;
        check("postrst DDone cycle", 128'(done_cyc), 128'(5));
        check("postrst DLine", 128'(d_line), {32'h73, 32'h72, 32'h71, 32'h70});

        // Line at the top of a 16-byte block; IAddr is scrambled once the burst starts.
        i_addr  = 32'h0000_77FC;
        rd_base = 32'h90;
        next_cycle();
        i_req      = 1'b1;
        bus.MemAck = 1'b1;
        #4;
        for (int k = 1; k <= 4; k++) begin
            next_cycle();
            i_addr = 32'hFFFF_0000 + 32'(k * 16);
            #4;
            check($sformatf("latch w%0d MemAddr", k), 128'(bus.MemAddr),
                  128'(32'h77F0 + 32'(4 * (k - 1))));
        end
        next_cycle();
        #4;
        check("latch IDone", 128'(i_done), 128'(1));
        next_cycle();
        i_req = 1'b0;
        check("latch ILine", 128'(i_line), {32'h93, 32'h92, 32'h91, 32'h90});
        check("latch line mask", 128'(32'h0000_77FC & LINE_MASK), 128'(32'h0000_77F0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
